bitbrick_seq_ctrl: RTL and testbench
====================================

Name: bitbrick_seq_ctrl

Overview:
Sequencing controller that performs one variable-precision multiply (2/4/8-bit operands, each independently signed or unsigned) using a single BitBrick 2x2 core.
- Decomposes both operands into 2-bit slices.
- Feeds one slice pair per cycle to the BitBrick.
- Shift-accumulates the 6-bit partial products into a 16-bit result.
- Sits between the operand fetch stage and the PE accumulator of the systolic array. Uses a valid/ready handshake on both sides.

Parameters:
MAX_BITS, 8, maximum operand width; slice count per operand = MAX_BITS/2.
OUT_W, 16, result width (2*MAX_BITS).
ACC_W, 18, internal accumulator width (OUT_W+2 guard bits).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operand request valid.
in_ready  output  1  controller can accept operands.
in_a  input  8  operand A; only the low prec_a bits are used.
in_b  input  8  operand B; only the low prec_b bits are used.
in_a_signed  input  1  A is two's complement.
in_b_signed  input  1  B is two's complement.
in_prec_a  input  2  A precision: 00=2b, 01=4b, 10=8b, 11=reserved (treated as 8b).
in_prec_b  input  2  B precision, same encoding.
out_valid  output  1  out_p holds a completed product.
out_ready  input  1  consumer accepts the product.
out_p  output  16  product, sign- or zero-extended to 16 bits.
busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Output reset values: in_ready=1 (in IDLE), out_valid=0, out_p=0, busy=0. Accumulator, slice counters and operand registers also reset to 0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch a, b, sign flags and precisions.
  - Set na = slices(prec_a) and nb = slices(prec_b), where slices = 1, 2 or 4.
  - Clear i, j and acc. Go to RUN.
- RUN (in_ready=0):
  - Each cycle, BitBrick inputs are X2b = a[2i+1:2i] and Y2b = b[2j+1:2j].
  - sx = a_signed && (i==na-1); sy = b_signed && (j==nb-1).
  - acc <= acc + (sext(P6b) << 2*(i+j)), computed in ACC_W bits.
  - j is the inner counter and wraps at nb; i increments when j wraps.
  - On the slice pair (na-1, nb-1): register out_p = (final acc)[15:0], set out_valid=1, go to DONE.
- Latency: out_valid rises exactly na*nb cycles after the accepting edge. Cases: 1 (2x2), 4 (4x4), 16 (8x8), 8 (4x8).
- DONE:
  - out_valid=1; out_p is held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE. in_ready returns high the next cycle.
  - No back-to-back overlap; in_valid is ignored outside IDLE.
- Result interpretation:
  - The exact mathematical product is representable in 17 bits; out_p is its low 16 bits.
  - Unsigned x unsigned 8x8 is exact as unsigned; any signed case is exact as two's complement.
  - Narrow precisions produce a result correctly sign/zero-extended to 16 bits.
- Upper operand bits above the selected precision have no effect on the result.
- rst_n assertion mid-RUN or in DONE:
  - Immediate return to IDLE; out_valid drops asynchronously.
  - The in-flight operation is discarded, not resumed.
- in_prec=11 behaves identically to 10.

Decomposition:
- Package bitfusion_pkg:
  - prec_e enum (PREC_2B, PREC_4B, PREC_8B, PREC_RSVD).
  - ctrl_state_e enum (IDLE, RUN, DONE).
  - Constants MAX_BITS and OUT_W.
  - Function prec_slices(prec_e) returning 1/2/4.
- One sub-module instance: the existing BitBrick core, driven purely combinationally from the slice muxes.
- Slice selection, sign-extension/shift and the FSM live in bitbrick_seq_ctrl.

Test Plan:
- 2b signed x 2b signed, in_a=8'hF3 (uses 2'b11 = -1), in_b=8'h02 (-2) -> out_p=16'h0002, out_valid 1 cycle after accept.
- 8b unsigned x 8b unsigned, 255*255 -> out_p=16'hFE01 after exactly 16 cycles.
- 8b signed: -128*-128 -> 16'h4000; -1*127 -> 16'hFF81; 0*-77 -> 16'h0000.
- Mixed: 4b signed a=4'b1000 (-8) x 8b unsigned b=200 -> out_p=16'hF9C0, latency 8 cycles.
- Backpressure: out_ready held low 5 cycles in DONE while in_valid=1 -> out_p stable, in_ready=0, no new accept. Release -> IDLE, in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n low at cycle 3 of a 16-cycle op -> out_valid=0 and busy=0 immediately. After release, 3x5 (4b unsigned) -> out_p=16'h000F.

Source files
------------

// File: rtl/bitfusion_pkg.sv
// rtl/bitfusion_pkg.sv - shared types and helpers for the BitFusion sequencing controller
package bitfusion_pkg;

  localparam int MAX_BITS = 8;
  localparam int OUT_W    = 16;

  typedef enum logic [1:0] {
    PREC_2B   = 2'b00,
    PREC_4B   = 2'b01,
    PREC_8B   = 2'b10,
    PREC_RSVD = 2'b11
  } prec_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ctrl_state_e;

  // Number of 2-bit slices an operand of the given precision occupies;
  // the reserved code behaves as full 8-bit precision.
  function automatic logic [2:0] prec_slices(prec_e p);
    case (p)
      PREC_2B: prec_slices = 3'd1;
      PREC_4B: prec_slices = 3'd2;
      default: prec_slices = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bitbrick.sv
// rtl/bitbrick.sv - BitBrick 2x2 core: signed/unsigned 2-bit by 2-bit multiply
module bitbrick (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       sx,
  input  logic       sy,
  output logic [5:0] p
);

  logic [5:0] x_ext;
  logic [5:0] y_ext;

  // Each slice becomes a 3-bit value (sign bit only for the top slice of a
  // signed operand), widened to 6 bits; the low 6 bits of the product are
  // the exact two's-complement result.
  always_comb begin
    x_ext = {{4{sx & x[1]}}, x};
    y_ext = {{4{sy & y[1]}}, y};
    p     = x_ext * y_ext;
  end

endmodule

// File: rtl/bitbrick_seq_ctrl.sv
// rtl/bitbrick_seq_ctrl.sv - sequences one variable-precision multiply through a single BitBrick
module bitbrick_seq_ctrl #(
  parameter int MAX_BITS = 8,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] in_a,
  input  logic [MAX_BITS-1:0] in_b,
  input  logic                in_a_signed,
  input  logic                in_b_signed,
  input  logic [1:0]          in_prec_a,
  input  logic [1:0]          in_prec_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_p,
  output logic                busy
);

  import bitfusion_pkg::*;

  localparam int NS = MAX_BITS / 2;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int SW = IW + 2;

  ctrl_state_e         state, state_nxt;
  logic [MAX_BITS-1:0] a_r, b_r;
  logic                a_sgn, b_sgn;
  logic [IW-1:0]       i_r, j_r, i_last, j_last;
  logic [ACC_W-1:0]    acc, acc_nxt, term;
  logic [SW-1:0]       shamt;
  logic [1:0]          x2, y2;
  logic                sx, sy;
  logic [5:0]          p6;
  logic                accept, j_wrap, last_pair;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign j_wrap    = (j_r == j_last);
  assign last_pair = (i_r == i_last) && j_wrap;

  // Slice muxes and sign control for the current (i, j) pair.
  always_comb begin
    x2    = a_r[{i_r, 1'b0} +: 2];
    y2    = b_r[{j_r, 1'b0} +: 2];
    sx    = a_sgn && (i_r == i_last);
    sy    = b_sgn && (j_r == j_last);
    shamt = {1'b0, i_r, 1'b0} + {1'b0, j_r, 1'b0};
    term  = {{(ACC_W-6){p6[5]}}, p6} << shamt;
    acc_nxt = acc + term;
  end

  bitbrick u_bitbrick (
    .x  (x2),
    .y  (y2),
    .sx (sx),
    .sy (sy),
    .p  (p6)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, walk all slice pairs in RUN, hold in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_pair) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice counters, shift-accumulate and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      a_sgn     <= 1'b0;
      b_sgn     <= 1'b0;
      i_r       <= '0;
      j_r       <= '0;
      i_last    <= '0;
      j_last    <= '0;
      acc       <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r    <= in_a;
            b_r    <= in_b;
            a_sgn  <= in_a_signed;
            b_sgn  <= in_b_signed;
            i_last <= IW'(prec_slices(prec_e'(in_prec_a)) - 3'd1);
            j_last <= IW'(prec_slices(prec_e'(in_prec_b)) - 3'd1);
            i_r    <= '0;
            j_r    <= '0;
            acc    <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (j_wrap) begin
            j_r <= '0;
            i_r <= i_r + IW'(1);
          end else begin
            j_r <= j_r + IW'(1);
          end
          if (last_pair) begin
            out_p     <= acc_nxt[OUT_W-1:0];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bitbrick_seq_ctrl.sv
// tb/tb_bitbrick_seq_ctrl.sv - self-checking bench for bitbrick_seq_ctrl
module tb_bitbrick_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic        in_a_signed, in_b_signed;
  logic [1:0]  in_prec_a, in_prec_b;
  logic        out_valid, out_ready;
  logic [15:0] out_p;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  bitbrick_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_a_signed (in_a_signed),
    .in_b_signed (in_b_signed),
    .in_prec_a   (in_prec_a),
    .in_prec_b   (in_prec_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_p       (out_p),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a, b;
    logic        as, bs;
    logic [1:0]  pa, pb;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int prec_width(input logic [1:0] p);
    return (p == 2'b00) ? 2 : (p == 2'b01) ? 4 : 8;
  endfunction

  function automatic int op_value(input logic [7:0] v, input logic s, input logic [1:0] p);
    int w = prec_width(p);
    int x = int'(v) % (1 << w);
    if (s && x >= (1 << (w - 1))) x = x - (1 << w);
    return x;
  endfunction

  function automatic logic [15:0] model_p(input logic [7:0] a, input logic [7:0] b,
                                          input logic as, input logic bs,
                                          input logic [1:0] pa, input logic [1:0] pb);
    int prod = op_value(a, as, pa) * op_value(b, bs, pb);
    return 16'(prod);
  endfunction

  function automatic int model_lat(input logic [1:0] pa, input logic [1:0] pb);
    return (prec_width(pa) / 2) * (prec_width(pb) / 2);
  endfunction

  // Issue one operation, wait (bounded) for the product, then complete the handshake.
  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    logic [15:0] p;
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_a_signed = v.as; in_b_signed = v.bs;
    in_prec_a = v.pa; in_prec_b = v.pb; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    p = out_p;
    chk({tag, "_lat"}, 32'(cyc), 32'(v.exp_lat));
    chk({tag, "_p"}, 32'(p), 32'(v.exp_p));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done_drop"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  vec_t vt[8];
  vec_t rv;
  logic [15:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0;
    in_prec_a = '0; in_prec_b = '0;

    vt[0] = '{8'hF3, 8'h02, 1'b1, 1'b1, 2'b00, 2'b00, 16'h0002, 1};
    vt[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 2'b10, 2'b10, 16'hFE01, 16};
    vt[2] = '{8'h80, 8'h80, 1'b1, 1'b1, 2'b10, 2'b10, 16'h4000, 16};
    vt[3] = '{8'hFF, 8'h7F, 1'b1, 1'b1, 2'b10, 2'b10, 16'hFF81, 16};
    vt[4] = '{8'h00, 8'hB3, 1'b1, 1'b1, 2'b10, 2'b10, 16'h0000, 16};
    vt[5] = '{8'hA8, 8'hC8, 1'b1, 1'b0, 2'b01, 2'b10, 16'hF9C0, 8};
    vt[6] = '{8'hF3, 8'h75, 1'b0, 1'b0, 2'b01, 2'b01, 16'h000F, 4};
    vt[7] = '{8'h9C, 8'h05, 1'b1, 1'b0, 2'b11, 2'b11, 16'hFE0C, 16};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run_op(vt[k], $sformatf("vec%0d", k));

    for (int k = 0; k < 40; k++) begin
      rv.a = 8'($urandom); rv.b = 8'($urandom);
      rv.as = 1'($urandom); rv.bs = 1'($urandom);
      rv.pa = 2'($urandom); rv.pb = 2'($urandom);
      rv.exp_p = model_p(rv.a, rv.b, rv.as, rv.bs, rv.pa, rv.pb);
      rv.exp_lat = model_lat(rv.pa, rv.pb);
      run_op(rv, $sformatf("rnd%0d", k));
    end

    // Backpressure: hold DONE with out_ready low while new requests are offered.
    @(negedge clk);
    in_a = 8'hF3; in_b = 8'h02; in_a_signed = 1'b1; in_b_signed = 1'b1;
    in_prec_a = 2'b00; in_prec_b = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 8'h55; in_b = 8'h66;
    @(posedge clk); #1;
    chk("bp_valid_rise", 32'(out_valid), 32'd1);
    held = 16'h0002;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c), {13'd0, out_valid, in_ready, busy, out_p}, {13'd0, 3'b101, held});
      @(posedge clk); #1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);

    // Reset in the middle of an 8x8 operation.
    @(negedge clk);
    in_a = 8'hFF; in_b = 8'hFF; in_a_signed = 1'b0; in_b_signed = 1'b0;
    in_prec_a = 2'b10; in_prec_b = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {29'd0, out_valid, busy, in_ready}, 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vt[6], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
